layer6_write_ctrl: RTL and testbench

//  Upstream producer/consumer controller for the layer6 dual-port SRAM (64 x 128b) wrapper.

---
 rtl/layer6_pkg.sv | 18 +
 rtl/layer6_packer.sv | 43 ++++
 rtl/layer6_write_ctrl.sv | 116 +++++++++++
 tb/tb_layer6_write_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer6_pkg.sv
// Shared types and sizing for the layer6 SRAM write/read controller.
// The SRAM is 64 words of 128 bits; each word packs eight 16-bit samples.
package layer6_pkg;
    localparam int L6_DATA_W = 16;
    localparam int L6_LANES  = 8;
    localparam int L6_DEPTH  = 64;
    localparam int L6_ADDR_W = 6;
    localparam int L6_LANE_W = $clog2(L6_LANES);
    localparam int L6_CNT_W  = L6_ADDR_W + 1;

    typedef logic [127:0] l6_word_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } l6_wr_state_e;
endpackage

// File: rtl/layer6_packer.sv
// Lane counter and pack register: gathers 16-bit samples into one 128-bit word.
// word_valid_o fires on the accept that completes a word (lane 7 or last sample).
module layer6_packer
    import layer6_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 flush_i,
    input  logic                 accept_i,
    input  logic [L6_DATA_W-1:0] data_i,
    input  logic                 last_i,
    output logic                 word_valid_o,
    output l6_word_t             word_o
);
    l6_word_t               pack_q, pack_d;
    logic [L6_LANE_W-1:0]   lane_q, lane_d;

    always_comb begin
        pack_d = pack_q;
        lane_d = lane_q;
        if (clear_i || flush_i) begin
            pack_d = '0;
            lane_d = '0;
        end else if (accept_i) begin
            pack_d[lane_q*L6_DATA_W +: L6_DATA_W] = data_i;
            lane_d = lane_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pack_q <= '0;
            lane_q <= '0;
        end else begin
            pack_q <= pack_d;
            lane_q <= lane_d;
        end
    end

    assign word_valid_o = accept_i && ((lane_q == L6_LANE_W'(L6_LANES - 1)) || last_i);
    assign word_o       = pack_q;
endmodule

// File: rtl/layer6_write_ctrl.sv
// Fills the layer6 SRAM through port A and serves downstream reads through port B.
// Reads are only granted for committed words, so port B never targets the word port A writes.
module layer6_write_ctrl
    import layer6_pkg::*;
(
    input  logic                 CK,
    input  logic                 RSTN,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [L6_DATA_W-1:0] in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic                 rd_req,
    input  logic [L6_ADDR_W-1:0] rd_addr,
    output logic                 rd_gnt,
    output logic                 rd_valid,
    output l6_word_t             rd_data,
    output logic [L6_CNT_W-1:0]  wr_count,
    output logic                 frame_done,
    output logic [L6_ADDR_W-1:0] sram_a,
    output logic                 sram_wean,
    output logic                 sram_oea,
    output l6_word_t             sram_dia,
    output logic [L6_ADDR_W-1:0] sram_b,
    output logic                 sram_webn,
    output logic                 sram_oeb,
    input  l6_word_t             sram_dob,
    output l6_wr_state_e         dbg_state_o
);
    l6_wr_state_e          state_q, state_d;
    logic [L6_CNT_W-1:0]   wr_count_q, wr_count_d;
    logic                  last_q, last_d;
    logic [L6_ADDR_W-1:0]  sram_b_q, sram_b_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  accept;
    logic                  flush;
    logic                  word_valid;
    l6_word_t              pack_word;

    // Handshakes: a sample transfers on a cycle where in_valid && in_ready; a read
    // transfers on a cycle where rd_gnt is high, and its data appears with rd_valid one cycle later.
    assign in_ready = (state_q == FILL) && !clear;
    assign accept   = in_valid && in_ready;
    assign flush    = (state_q == WRITE);

    layer6_packer u_packer (
        .clk_i        (CK),
        .rst_ni       (RSTN),
        .clear_i      (clear),
        .flush_i      (flush),
        .accept_i     (accept),
        .data_i       (in_data),
        .last_i       (in_last),
        .word_valid_o (word_valid),
        .word_o       (pack_word)
    );

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        last_d     = last_q;
        case (state_q)
            FILL: begin
                if (accept && in_last) last_d = 1'b1;
                if (word_valid)        state_d = WRITE;
            end
            WRITE: begin
                wr_count_d = wr_count_q + 1'b1;
                last_d     = 1'b0;
                state_d    = ((wr_count_q == L6_CNT_W'(L6_DEPTH - 1)) || last_q) ? DONE : FILL;
            end
            DONE:    state_d = DONE;
            default: state_d = FILL;
        endcase
        // A clear overrides everything, including cancelling an in-flight WRITE.
        if (clear) begin
            state_d    = FILL;
            wr_count_d = '0;
            last_d     = 1'b0;
        end
    end

    assign rd_gnt     = rd_req && !clear && ({1'b0, rd_addr} < wr_count_q);
    assign sram_b_d   = rd_gnt ? rd_addr : sram_b_q;
    assign rd_valid_d = rd_gnt;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= FILL;
            wr_count_q <= '0;
            last_q     <= 1'b0;
            sram_b_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            last_q     <= last_d;
            sram_b_q   <= sram_b_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // wr_count doubles as the write address; it only reaches DEPTH once in DONE.
    assign sram_a      = wr_count_q[L6_ADDR_W-1:0];
    assign sram_wean   = !((state_q == WRITE) && !clear);
    assign sram_oea    = 1'b0;
    assign sram_dia    = pack_word;
    assign sram_b      = sram_b_q;
    assign sram_webn   = 1'b1;
    assign sram_oeb    = rd_valid_q;
    assign rd_valid    = rd_valid_q && !clear;
    assign rd_data     = rd_valid ? sram_dob : '0;
    assign wr_count    = wr_count_q;
    assign frame_done  = (state_q == DONE);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_layer6_write_ctrl.sv
// Directed bench for layer6_write_ctrl with a behavioural SRAM and a write scoreboard.
module tb_layer6_write_ctrl;
    import layer6_pkg::*;

    logic         CK;
    logic         RSTN;
    logic         clear;
    logic         in_valid;
    logic [15:0]  in_data;
    logic         in_last;
    logic         in_ready;
    logic         rd_req;
    logic [5:0]   rd_addr;
    logic         rd_gnt;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic [6:0]   wr_count;
    logic         frame_done;
    logic [5:0]   sram_a;
    logic         sram_wean;
    logic         sram_oea;
    logic [127:0] sram_dia;
    logic [5:0]   sram_b;
    logic         sram_webn;
    logic         sram_oeb;
    logic [127:0] sram_dob;
    l6_wr_state_e dbg_state;

    logic [127:0] mem [64];
    logic [127:0] exp_q[$];
    logic [5:0]   exp_addr_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_writes = 0;
    int           cyc = 0;
    int           waited;
    int           t_start;
    int           writes_before;

    layer6_write_ctrl dut (
        .CK(CK), .RSTN(RSTN), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_count(wr_count), .frame_done(frame_done),
        .sram_a(sram_a), .sram_wean(sram_wean), .sram_oea(sram_oea), .sram_dia(sram_dia),
        .sram_b(sram_b), .sram_webn(sram_webn), .sram_oeb(sram_oeb), .sram_dob(sram_dob),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial CK = 1'b0;
    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] build_word(input logic [15:0] base);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w[j*16 +: 16] = base + 16'(j);
        return w;
    endfunction

    // behavioural SRAM plus write scoreboard
    assign sram_dob = sram_oeb ? mem[sram_b] : '0;

    always @(negedge CK) begin
        if (RSTN) begin
            if (!sram_wean) begin
                n_writes <= n_writes + 1;
                mem[sram_a] <= sram_dia;
                check("write_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    check("wr_addr", sram_a, exp_addr_q.pop_front());
                    check("wr_data", sram_dia, exp_q.pop_front());
                end
                if (sram_oeb) check("collision", sram_a != sram_b, 1'b1);
            end
            if (sram_oeb) check("rd_addr_committed", {1'b0, sram_b} < wr_count, 1'b1);
        end
    end

    // driver tasks; each starts and ends 1 time unit after a rising edge
    task automatic tick();
        @(posedge CK); #1;
    endtask

    task automatic send_sample(input logic [15:0] d, input logic last);
        int guard;
        guard = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        #0;
        while (!in_ready && guard < 20) begin
            tick(); guard++;
        end
        check("in_ready_timeout", guard < 20, 1'b1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] addr, input logic [127:0] exp, output int w);
        w = 0;
        rd_req = 1'b1; rd_addr = addr;
        #1;
        while (!rd_gnt && w < 200) begin
            @(posedge CK); #2; w++;
        end
        check("rd_gnt_timeout", rd_gnt, 1'b1);
        tick();
        rd_req = 1'b0;
        check("rd_valid", rd_valid, 1'b1);
        check("rd_data", rd_data, exp);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic push_exp(input logic [5:0] a, input logic [127:0] w);
        exp_addr_q.push_back(a);
        exp_q.push_back(w);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        RSTN = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        repeat (3) @(posedge CK);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 128'h0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_wean", sram_wean, 1'b1);
        check("rst_oeb", sram_oeb, 1'b0);
        check("rst_sram_a", sram_a, 6'd0);
        check("rst_sram_b", sram_b, 6'd0);
        check("rst_wr_count", wr_count, 7'd0);
        check("rst_state", dbg_state, FILL);
        check("tie_oea", sram_oea, 1'b0);
        check("tie_webn", sram_webn, 1'b1);
        RSTN = 1'b1;
        tick();

        // full frame of 512 samples, no in_last
        for (int k = 0; k < 64; k++) push_exp(6'(k), build_word(16'(8 * k)));
        t_start = cyc;
        writes_before = n_writes;
        for (int i = 0; i < 512; i++) send_sample(16'(i), 1'b0);
        check("fill_cycles", cyc - t_start, 575);
        check("t1_last_write_wean", sram_wean, 1'b0);
        check("t1_last_write_addr", sram_a, 6'd63);
        check("t1_done_before", frame_done, 1'b0);
        tick();
        check("t1_frame_done", frame_done, 1'b1);
        check("t1_wr_count", wr_count, 7'd64);
        check("t1_in_ready", in_ready, 1'b0);
        check("t1_state", dbg_state, DONE);
        check("t1_writes", n_writes - writes_before, 64);
        do_read(6'd63, build_word(16'd504), waited);
        do_read(6'd0, build_word(16'd0), waited);
        tick();
        check("t1_still_done", frame_done, 1'b1);

        // short frame: 3 samples then in_last
        pulse_clear();
        check("t2_cleared_count", wr_count, 7'd0);
        push_exp(6'd0, {80'h0, 16'h8000, 16'h0003, 16'hFFFE});
        send_sample(16'hFFFE, 1'b0);
        send_sample(16'h0003, 1'b0);
        send_sample(16'h8000, 1'b1);
        tick();
        check("t2_frame_done", frame_done, 1'b1);
        check("t2_wr_count", wr_count, 7'd1);
        check("t2_in_ready", in_ready, 1'b0);

        // read of an unwritten word stalls until it commits
        pulse_clear();
        for (int k = 0; k < 8; k++) push_exp(6'(k), build_word(16'(100 + 8 * k)));
        for (int i = 0; i < 40; i++) send_sample(16'(100 + i), 1'b0);
        tick();
        check("t3_wr_count", wr_count, 7'd5);
        rd_req = 1'b1; rd_addr = 6'd5;
        #1;
        check("t3_gnt_unwritten", rd_gnt, 1'b0);
        fork
            begin
                for (int i = 40; i < 48; i++) send_sample(16'(100 + i), 1'b0);
            end
            do_read(6'd5, build_word(16'd140), waited);
        join
        check("t3_stall_cycles", waited, 9);

        // back-to-back reads while the frame keeps filling
        fork
            begin
                for (int i = 48; i < 64; i++) send_sample(16'(100 + i), 1'b0);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    rd_req = 1'b1; rd_addr = 6'(i);
                    #1;
                    check("t4_gnt", rd_gnt, 1'b1);
                    if (i > 0) begin
                        check("t4_valid", rd_valid, 1'b1);
                        check("t4_data", rd_data, build_word(16'(100 + 8 * (i - 1))));
                    end
                    tick();
                end
                rd_req = 1'b0;
                #1;
                check("t4_valid_last", rd_valid, 1'b1);
                check("t4_data_last", rd_data, build_word(16'd124));
            end
        join
        tick();
        check("t4_wr_count", wr_count, 7'd8);

        // clear in the WRITE cycle cancels the write
        pulse_clear();
        for (int i = 0; i < 8; i++) send_sample(16'(16'h1000 + i), 1'b0);
        check("t5_in_write", dbg_state, WRITE);
        check("t5_wean_before", sram_wean, 1'b0);
        writes_before = n_writes;
        clear = 1'b1;
        #1;
        check("t5_wean_cancel", sram_wean, 1'b1);
        tick();
        clear = 1'b0;
        #0;
        check("t5_wr_count", wr_count, 7'd0);
        check("t5_in_ready", in_ready, 1'b1);
        check("t5_state", dbg_state, FILL);
        check("t5_no_write", n_writes - writes_before, 0);
        push_exp(6'd0, {112'h0, 16'hBEEF});
        send_sample(16'hBEEF, 1'b1);
        tick();
        check("t5_frame_done", frame_done, 1'b1);
        check("t5_wr_count_after", wr_count, 7'd1);

        // asynchronous reset mid-word
        pulse_clear();
        for (int i = 0; i < 3; i++) send_sample(16'(16'h2000 + i), 1'b0);
        RSTN = 1'b0;
        #1;
        check("t6_in_ready", in_ready, 1'b1);
        check("t6_wr_count", wr_count, 7'd0);
        check("t6_frame_done", frame_done, 1'b0);
        check("t6_rd_valid", rd_valid, 1'b0);
        check("t6_wean", sram_wean, 1'b1);
        check("t6_oeb", sram_oeb, 1'b0);
        check("t6_sram_a", sram_a, 6'd0);
        check("t6_sram_b", sram_b, 6'd0);
        check("t6_state", dbg_state, FILL);
        tick();
        RSTN = 1'b1;
        tick();
        push_exp(6'd0, build_word(16'h3000));
        for (int i = 0; i < 8; i++) send_sample(16'(16'h3000 + i), 1'b0);
        tick();
        check("t6_wr_count_after", wr_count, 7'd1);
        do_read(6'd0, build_word(16'h3000), waited);

        tick();
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
